// File: rtl/hack_boot_pkg.sv
// Shared types and constants for the hack_soc ROM boot sequencer.
package hack_boot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLdrRst,
        StFetch,
        StLoad,
        StWaitAck,
        StRelease,
        StRun,
        StError
    } boot_state_e;

    localparam int unsigned LDR_RST_CYCLES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // A timer loaded with (n - 1) expires on the n-th cycle after loading.
    function automatic int unsigned preload(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/hack_boot_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module hack_boot_timeout #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/hack_boot_loader.sv
// Boot sequencer: streams a ROM image into the hack_soc loader, then releases the CPU.
// Defining HACK_BOOT_CHECKSUM_EN adds a modular-sum image check before release.
module hack_boot_loader
    import hack_boot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned RELEASE_DELAY  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_last,
`ifdef HACK_BOOT_CHECKSUM_EN
    input  logic [DATA_WIDTH-1:0]  expected_checksum,
    output logic [DATA_WIDTH-1:0]  checksum,
`endif
    output logic                   rom_loader_reset,
    output logic                   rom_loader_load,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_load_received,
    input  logic                   rom_loader_ack,
    output logic                   hack_external_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded
);

    localparam int unsigned TIMER_MAX =
        max_u(max_u(TIMEOUT_CYCLES, RELEASE_DELAY), LDR_RST_CYCLES);
    localparam int unsigned TIMER_WIDTH = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_WIDTH-1:0] TMR_TIMEOUT = TIMER_WIDTH'(preload(TIMEOUT_CYCLES));
    localparam logic [TIMER_WIDTH-1:0] TMR_RELEASE = TIMER_WIDTH'(preload(RELEASE_DELAY));
    localparam logic [TIMER_WIDTH-1:0] TMR_LDR_RST = TIMER_WIDTH'(preload(LDR_RST_CYCLES));

    boot_state_e            state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic [COUNT_WIDTH-1:0] words_next;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   last_q, last_d;

    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   timer_expired;

    logic                   accept;
    logic                   load_start;
    logic                   go_release;
    logic                   release_ok;

    assign accept     = (state_q == StFetch) && s_valid;
    assign words_next = words_q + COUNT_WIDTH'(1);

    hack_boot_timeout #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        words_d     = words_q;
        data_d      = data_q;
        last_d      = last_q;
        timer_load  = 1'b0;
        timer_value = TMR_TIMEOUT;
        load_start  = 1'b0;
        go_release  = 1'b0;

        unique case (state_q)
            StIdle, StError: begin
                if (start) begin
                    load_start  = 1'b1;
                    state_d     = StLdrRst;
                    count_d     = word_count;
                    words_d     = '0;
                    timer_load  = 1'b1;
                    timer_value = TMR_LDR_RST;
                end
            end
            StLdrRst: begin
                if (timer_expired) begin
                    if (count_q == '0) begin
                        go_release = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (accept) begin
                    data_d = s_data;
                    last_d = s_last;
                    // A last marker before the final counted word truncates the image.
                    if (s_last && (words_next != count_q)) begin
                        state_d = StError;
                    end else begin
                        state_d    = StLoad;
                        timer_load = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (rom_loader_load_received) begin
                    state_d    = StWaitAck;
                    timer_load = 1'b1;
                end else if (timer_expired) begin
                    state_d = StError;
                end
            end
            StWaitAck: begin
                if (rom_loader_ack) begin
                    if (words_q != count_q) begin
                        words_d = words_next;
                    end
                    if (words_next == count_q) begin
                        if (last_q) begin
                            go_release = 1'b1;
                        end else begin
                            state_d = StError;
                        end
                    end else begin
                        state_d = StFetch;
                    end
                end else if (timer_expired) begin
                    state_d = StError;
                end
            end
            StRelease: begin
                if (timer_expired) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
        endcase

        if (go_release) begin
            if (release_ok) begin
                state_d     = StRelease;
                timer_load  = 1'b1;
                timer_value = TMR_RELEASE;
            end else begin
                state_d = StError;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            words_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

`ifdef HACK_BOOT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (load_start) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + s_data;
        end
    end

    assign checksum   = sum_q;
    assign release_ok = (sum_q == expected_checksum);
`else
    assign release_ok = 1'b1;
`endif

    assign s_ready             = (state_q == StFetch);
    assign rom_loader_reset    = (state_q == StLdrRst);
    assign rom_loader_load     = (state_q == StLoad);
    assign rom_loader_data     = data_q;
    assign hack_external_reset = (state_q != StRun);
    assign busy                = !(state_q inside {StIdle, StRun, StError});
    // RUN and ERROR are only left via reset or restart, so state encodes the sticky flags.
    assign done                = (state_q == StRun);
    assign error               = (state_q == StError);
    assign words_loaded        = words_q;

endmodule

// File: doc/hack_boot_loader.md
Name: hack_boot_loader

Overview:
- Parametrised ROM boot sequencer for hack_soc.
- Accepts a word stream over valid/ready, with a runtime word count, and drives the SoC ROM-loader handshake (rom_loader_reset/load/data, ack/load_received) word by word.
- Holds the Hack CPU in reset until the image is written, then releases it.
- Reports done, error and progress.
- Replaces the fixed-length file-driven loader plus ad-hoc ready_to_start logic in bench and FPGA tops.

Parameters:
- DATA_WIDTH, 16, instruction word width.
- COUNT_WIDTH, 16, width of word_count and words_loaded.
- TIMEOUT_CYCLES, 4096, max cycles waiting on load_received or ack before error.
- RELEASE_DELAY, 4, cycles between last ack and hack_external_reset deassert.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse begins a load
- word_count  in  COUNT_WIDTH  words to load; sampled on start
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid&&s_ready
- s_data  in  DATA_WIDTH  stream word
- s_last  in  1  marks final stream word
- rom_loader_reset  out  1  SoC loader reset
- rom_loader_load  out  1  word-present strobe to SoC
- rom_loader_data  out  DATA_WIDTH  word to SoC
- rom_loader_load_received  in  1  SoC captured the word
- rom_loader_ack  in  1  SoC finished writing the word
- hack_external_reset  out  1  Hack CPU reset, active-high
- busy  out  1  load in progress
- done  out  1  sticky, image loaded and CPU released
- error  out  1  sticky, load aborted
- words_loaded  out  COUNT_WIDTH  words acked so far

Behaviour:
- Reset values while reset_n=0 at a clk edge:
  - All outputs 0, except hack_external_reset=1.
  - State IDLE.
- Reset mid-load: abandons the load immediately, with the same values. The SoC ROM contents are undefined afterwards.
- IDLE:
  - s_ready=0.
  - On start: latch word_count, clear done/error/words_loaded, go to LDR_RST.
  - busy=1 in every state except IDLE, RUN and ERROR.
- LDR_RST:
  - rom_loader_reset=1 for exactly 2 cycles.
  - Then go to FETCH, or straight to RELEASE if the latched count is 0.
- FETCH:
  - s_ready=1.
  - On accept: register s_data into rom_loader_data and go to LOAD.
  - s_last on a word that is not the final counted word goes to ERROR.
- LOAD:
  - rom_loader_load=1; rom_loader_data is held stable.
  - Wait for rom_loader_load_received=1, then drop load next cycle and go to WAIT_ACK.
- WAIT_ACK:
  - Wait for rom_loader_ack=1, then increment words_loaded.
  - If words_loaded now equals the count, go to RELEASE; otherwise go to FETCH.
  - The final counted word must carry s_last=1; if it does not, go to ERROR after its ack.
- Timeout: one counter, reset on entering LOAD and on entering WAIT_ACK. Reaching TIMEOUT_CYCLES in either state goes to ERROR.
- RELEASE: count RELEASE_DELAY cycles. Then hack_external_reset=0, done=1, go to RUN.
- RUN:
  - CPU runs; start is ignored.
  - Only reset_n returns to IDLE.
- ERROR:
  - error=1, hack_external_reset=1, rom_loader_load=0.
  - start restarts from LDR_RST.
- start outside IDLE/ERROR is ignored.
- load_received or ack arriving outside the expected state is ignored.
- Minimum per-word latency: 1 FETCH + 1 LOAD + 1 WAIT_ACK cycle, with immediate responses.
- words_loaded saturates at the latched count. Arithmetic is unsigned, modulo 2^COUNT_WIDTH; there is no wrap beyond count.

Optional Feature:
- Macro: HACK_BOOT_CHECKSUM_EN.
- Defined:
  - Adds input expected_checksum (DATA_WIDTH) and output checksum (DATA_WIDTH).
  - checksum is the modulo-2^DATA_WIDTH sum of accepted words. It is cleared on start.
  - At the RELEASE entry, a mismatch goes to ERROR instead; the CPU stays in reset.
- Undefined: no extra ports; no check.

Decomposition:
- Shared package hack_boot_pkg holds:
  - The state enum: IDLE, LDR_RST, FETCH, LOAD, WAIT_ACK, RELEASE, RUN, ERROR.
  - The LDR_RST_CYCLES=2 constant.
- One sub-module, hack_boot_timeout: a loadable down-counter with an expired flag, shared by the timeout and RELEASE delay.

Test Plan:
- Nominal load:
  - Stimulus: start with count=3, words 0x0005,0xEC10,0x0000 (last on 3rd); SoC model gives load_received after 1 cycle and ack after 3 cycles.
  - Required: 3 load pulses carrying those words; words_loaded=3; hack_external_reset falls 4 cycles after the 3rd ack; done=1.
- Zero count:
  - Stimulus: start with count=0.
  - Required: 2-cycle rom_loader_reset; no load; done after RELEASE_DELAY.
- Early s_last:
  - Stimulus: count=4, s_last on the 2nd word.
  - Required: error=1; words_loaded=1; hack_external_reset stays 1.
- Ack timeout:
  - Stimulus: SoC never acks.
  - Required: error exactly TIMEOUT_CYCLES cycles after entering WAIT_ACK; load=0.
- Reset mid-load:
  - Stimulus: reset_n=0 during LOAD of word 2, then start with count=2.
  - Required: all outputs at reset values; a fresh full load completes.
- Checksum (HACK_BOOT_CHECKSUM_EN):
  - Stimulus: words 0xFFFF,0x0002; expected_checksum 0x0001 passes, 0x0002 fails.
  - Required: pass gives done; fail gives error, with the CPU held in reset.
